bit_field_extractor: RTL
========================

Name: bit_field_extractor

Overview:
- Two-stage pipelined bit-field extract and extend unit for the CPU_NN datapath.
- Takes a raw instruction or data word plus a runtime field descriptor (lsb, length, signedness).
- Returns the field zero- or sign-extended to OUT_W bits.
- Has valid/ready handshakes on both sides, so it sits between decode and the ALU operand muxes and absorbs ALU back-pressure.

Parameters:
- DATA_W, 32, width of the source word; must be ≥ 2.
- OUT_W, 32, width of the extended result; must be ≥ DATA_W, otherwise elaboration error.
- LSB_W, $clog2(DATA_W), width of the lsb and len fields (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- in_word  in  DATA_W  source word.
- in_lsb  in  LSB_W  bit index of field LSB.
- in_len_m1  in  LSB_W  field length minus 1 (0 means 1 bit, DATA_W-1 means full word).
- in_signed  in  1  1 = sign-extend, 0 = zero-extend.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  OUT_W  extended field.
- out_trunc  out  1  requested field ran past bit DATA_W-1.

Behaviour:
- Transfer rule: a transfer occurs on a side when valid && ready at a rising clk edge. Once asserted, out_valid and out_data/out_trunc hold stable until accepted.
- Stage 1 (registered):
  - s1_field = in_word >> in_lsb, with zeros shifted in.
  - eff_len = min(in_len_m1+1, DATA_W-in_lsb), computed at LSB_W+1 bits with no wrap.
  - Also registers in_signed and trunc = (in_lsb + in_len_m1 + 1 > DATA_W).
- Stage 2 (registered to outputs):
  - Mask s1_field to its eff_len low bits.
  - If signed, replicate bit eff_len-1 into bits OUT_W-1..eff_len; otherwise fill with zeros.
- Pipeline control:
  - Each stage has its own valid flag. A stage loads when it is empty or its contents move downstream the same cycle.
  - in_ready = !s1_valid || (!s2_valid || out_ready). This is combinational from out_ready; no other combinational path exists from in_* to out_*.
- Latency and throughput: 2 cycles from accepted request to out_valid with out_ready held high. Sustained 1 result/cycle.
- Back-pressure: with out_ready low, both stages fill and in_ready drops on the cycle after the second accepted request. No request is ever lost or duplicated.
- Simultaneous events: a full pipe with out_ready=1 and in_valid=1 accepts the new request and shifts both stages in the same edge.
- Boundaries:
  - Full-word field (lsb=0, len_m1=DATA_W-1) passes through unmodified before extension.
  - A 1-bit signed field of value 1 yields all-ones.
  - Truncated fields use the truncated MSB as the sign bit and assert out_trunc with the result.
- Reset:
  - Asynchronous assertion at any time, including mid-transfer, clears s1_valid, s2_valid, out_data and out_trunc to 0.
  - in_ready reads 1 from the first edge after deassertion.
  - In-flight requests are discarded.

Optional Feature:
- Macro: FIELDEXT_SHL_EN.
- When defined:
  - Adds input port in_shl [1:0], registered in stage 1.
  - Stage 2 left-shifts the extended result by in_shl (0..3 bits, zeros in, MSBs dropped) for scaled branch and word offsets.
  - Latency is unchanged.
- When undefined: the port is absent and behaviour equals in_shl=0.

Decomposition:
- Package fieldext_pkg holds:
  - lsb_w(DATA_W) function.
  - Field descriptor struct {lsb, len_m1, signed, shl}.
  - Stage-1 payload struct {field, eff_len, signed, trunc, shl}.
- One sub-module: pipe_reg_slice, a parametrised-width valid/ready register stage with async active-low reset. It is instantiated twice; the extract/extend logic stays in the top.

Test Plan:
- Sign extension (DATA_W=OUT_W=32):
  - word=0x0000_8000, lsb=0, len_m1=15, signed=1, out_ready=1 → out_data=0xFFFF_8000, trunc=0, 2 cycles after accept.
  - Same request with signed=0 → 0x0000_8000.
- Mid-word field: word=0xABCD_1234, lsb=8, len_m1=7, signed=1 → field 0x12 → out_data=0x0000_0012. With lsb=12, len_m1=3 → 0x1 → 0x0000_0001.
- Truncation: word=0x8000_0000, lsb=28, len_m1=7, signed=1 → eff_len=4, field 0x8 → out_data=0xFFFF_FFF8, out_trunc=1.
- Back-pressure: 4 back-to-back requests with out_ready=0 → exactly 2 accepted, in_ready=0 thereafter. Raise out_ready → all 4 results delivered in order with no gaps or duplicates.
- Reset: assert rst_n=0 with both stages valid → out_valid=0, out_data=0 immediately (async). After release, a new request yields the correct result 2 cycles later.
- FIELDEXT_SHL_EN build: word=0x0000_00FF, lsb=0, len_m1=7, signed=1, in_shl=2 → out_data=0xFFFF_FFFC.

Source files
------------

// File: rtl/fieldext_pkg.sv
// Shared widths, field descriptor and stage payload types for bit_field_extractor.
// Struct widths follow FE_DATA_W / FE_OUT_W; the top ties its parameters to them.
package fieldext_pkg;

  function automatic int lsb_w(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

  localparam int FE_DATA_W = 32;
  localparam int FE_OUT_W  = 32;
  localparam int FE_LSB_W  = lsb_w(FE_DATA_W);

  typedef struct packed {
    logic [FE_LSB_W-1:0] lsb;
    logic [FE_LSB_W-1:0] len_m1;
    logic                is_signed;
    logic [1:0]          shl;
  } field_desc_t;

  typedef struct packed {
    logic [FE_DATA_W-1:0] field;
    logic [FE_LSB_W:0]    eff_len;
    logic                 is_signed;
    logic                 trunc;
    logic [1:0]           shl;
  } s1_payload_t;

  typedef struct packed {
    logic [FE_OUT_W-1:0] data;
    logic                trunc;
  } s2_payload_t;

endpackage

// File: rtl/pipe_reg_slice.sv
// One valid/ready register stage: loads when empty or when its content leaves this cycle.
module pipe_reg_slice #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      // NOTE: payload is reset too, so outputs read 0 while the stage is empty after reset.
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/bit_field_extractor.sv
// Two-stage bit-field extract and zero/sign-extend unit with valid/ready on both sides.
// Optional FIELDEXT_SHL_EN adds in_shl: post-extension left shift by 0..3 bits.
module bit_field_extractor
  import fieldext_pkg::*;
#(
  parameter int  DATA_W = FE_DATA_W,
  parameter int  OUT_W  = FE_OUT_W,
  localparam int LSB_W  = lsb_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_word,
  input  logic [LSB_W-1:0]  in_lsb,
  input  logic [LSB_W-1:0]  in_len_m1,
  input  logic              in_signed,
`ifdef FIELDEXT_SHL_EN
  input  logic [1:0]        in_shl,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_trunc
);

  if (DATA_W < 2) begin : g_bad_data_w
    $error("bit_field_extractor: DATA_W must be >= 2");
  end
  if (OUT_W < DATA_W) begin : g_bad_out_w
    $error("bit_field_extractor: OUT_W must be >= DATA_W");
  end
  if (DATA_W != FE_DATA_W || OUT_W != FE_OUT_W) begin : g_pkg_w
    $error("bit_field_extractor: DATA_W/OUT_W must match fieldext_pkg FE_DATA_W/FE_OUT_W");
  end

  logic [1:0] shl_in;
`ifdef FIELDEXT_SHL_EN
  assign shl_in = in_shl;
`else
  assign shl_in = 2'b00;
`endif

  // Stage 1: shift the field down and work out how many of its bits exist in the word.
  field_desc_t       desc;
  s1_payload_t       s1_next;
  logic [LSB_W:0]    len_full;
  logic [LSB_W:0]    room;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    desc           = '0;
    desc.lsb       = in_lsb;
    desc.len_m1    = in_len_m1;
    desc.is_signed = in_signed;
    desc.shl       = shl_in;

    len_full = {1'b0, desc.len_m1} + (LSB_W + 1)'(1);
    if ({1'b0, desc.lsb} >= (LSB_W + 1)'(DATA_W)) room = '0;
    else room = (LSB_W + 1)'(DATA_W) - {1'b0, desc.lsb};

    s1_next           = '0;
    s1_next.field     = in_word >> desc.lsb;
    s1_next.eff_len   = (len_full < room) ? len_full : room;
    s1_next.is_signed = desc.is_signed;
    s1_next.trunc     = (len_full > room);
    s1_next.shl       = desc.shl;
  end

  logic        s1_valid;
  logic        s2_in_ready;
  s1_payload_t s1_q;

  pipe_reg_slice #(.W($bits(s1_payload_t))) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_next),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_q)
  );

  // Stage 2: keep eff_len low bits, fill above with the field's top bit or zero, then scale.
  s2_payload_t      s2_next;
  logic [OUT_W-1:0] ext;
  logic             sign_bit;
  logic             fill;

  always_comb begin
    sign_bit = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i == int'(s1_q.eff_len) - 1) sign_bit = s1_q.field[i];
    end
    fill = s1_q.is_signed & sign_bit;

    ext = '0;
    for (int i = 0; i < OUT_W; i++) ext[i] = fill;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(s1_q.eff_len)) ext[i] = s1_q.field[i];
    end

    s2_next       = '0;
    s2_next.data  = ext << s1_q.shl;
    s2_next.trunc = s1_q.trunc;
  end

  s2_payload_t s2_q;

  pipe_reg_slice #(.W($bits(s2_payload_t))) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_next),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

  assign out_data  = s2_q.data;
  assign out_trunc = s2_q.trunc;

endmodule
